// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-style pipeline: ALU command encodings,
// default datapath widths and the 12-bit shift-operand field positions.
package arm_pkg;

  localparam int ARM_DW = 32;
  localparam int ARM_RW = 4;

  // Several mnemonics share an ALU operation, so plain constants are used here rather than an enum.
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_CMP = 4'b0100;
  localparam logic [3:0] EXE_TST = 4'b0110;
  localparam logic [3:0] EXE_LDR = 4'b0010;
  localparam logic [3:0] EXE_STR = 4'b0010;

  localparam int SH_ROT_MSB   = 11;
  localparam int SH_ROT_LSB   = 8;
  localparam int SH_IMM8_MSB  = 7;
  localparam int SH_IMM8_LSB  = 0;
  localparam int SH_TYPE_MSB  = 6;
  localparam int SH_TYPE_LSB  = 5;
  localparam int SH_REG_FLAG  = 4;

endpackage

// File: rtl/id_exe_reg_sat_counter.sv
// Width-parameterised saturating up-counter with enable.
// It sticks at all-ones and clears only on asynchronous reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze (hold) and flush (bubble).
// Define ID_EXE_PERF_EN to build the freeze/flush performance counters.
module id_exe_reg
  import arm_pkg::*;
#(
  parameter int DW = ARM_DW,
  parameter int RW = ARM_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          flush,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] val_rn_in,
  input  logic [DW-1:0] val_rm_in,
  input  logic          imm_in,
  input  logic [11:0]   shift_operand_in,
  input  logic [23:0]   signed_imm24_in,
  input  logic [RW-1:0] dest_in,
  input  logic [3:0]    exe_cmd_in,
  input  logic          mem_r_en_in,
  input  logic          mem_w_en_in,
  input  logic          wb_en_in,
  input  logic          b_in,
  input  logic          s_in,
  input  logic [3:0]    sr_in,
  output logic [DW-1:0] pc_out,
  output logic [DW-1:0] val_rn_out,
  output logic [DW-1:0] val_rm_out,
  output logic          imm_out,
  output logic [11:0]   shift_operand_out,
  output logic [23:0]   signed_imm24_out,
  output logic [RW-1:0] dest_out,
  output logic [3:0]    exe_cmd_out,
  output logic          mem_r_en_out,
  output logic          mem_w_en_out,
  output logic          wb_en_out,
  output logic          b_out,
  output logic          s_out,
  output logic [3:0]    sr_out,
  output logic          ld_or_str_out,
  output logic          valid_out,
  output logic [15:0]   freeze_cnt_out,
  output logic [15:0]   flush_cnt_out
);

  // Flush beats freeze: the decode-stage instruction is wrong-path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      if (rst || flush) begin
        pc_out            <= '0;
        val_rn_out        <= '0;
        val_rm_out        <= '0;
        imm_out           <= 1'b0;
        shift_operand_out <= '0;
        signed_imm24_out  <= '0;
        dest_out          <= '0;
        exe_cmd_out       <= EXE_NOP;
        mem_r_en_out      <= 1'b0;
        mem_w_en_out      <= 1'b0;
        wb_en_out         <= 1'b0;
        b_out             <= 1'b0;
        s_out             <= 1'b0;
        sr_out            <= '0;
        ld_or_str_out     <= 1'b0;
        valid_out         <= 1'b0;
      end
    end else if (!freeze) begin
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      imm_out           <= imm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm24_out  <= signed_imm24_in;
      dest_out          <= dest_in;
      exe_cmd_out       <= exe_cmd_in;
      mem_r_en_out      <= mem_r_en_in;
      mem_w_en_out      <= mem_w_en_in;
      wb_en_out         <= wb_en_in;
      b_out             <= b_in;
      s_out             <= s_in;
      sr_out            <= sr_in;
      ld_or_str_out     <= mem_r_en_in | mem_w_en_in;
      valid_out         <= 1'b1;
    end
  end

`ifdef ID_EXE_PERF_EN
  logic freeze_inc;
  assign freeze_inc = freeze & ~flush;

  sat_counter #(.W(16)) u_freeze_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (freeze_inc),
    .cnt_o (freeze_cnt_out)
  );

  sat_counter #(.W(16)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (flush),
    .cnt_o (flush_cnt_out)
  );
`else
  assign freeze_cnt_out = 16'h0000;
  assign flush_cnt_out  = 16'h0000;
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for id_exe_reg: a per-cycle behavioural model plus literal pins.
// Builds with or without ID_EXE_PERF_EN.
module tb_id_exe_reg;
  localparam int DW = 32;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          freeze = 1'b0, flush = 1'b0;
  logic [DW-1:0] pc_in = '0, val_rn_in = '0, val_rm_in = '0;
  logic          imm_in = 1'b0;
  logic [11:0]   shift_operand_in = '0;
  logic [23:0]   signed_imm24_in = '0;
  logic [RW-1:0] dest_in = '0;
  logic [3:0]    exe_cmd_in = '0;
  logic          mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, wb_en_in = 1'b0, b_in = 1'b0, s_in = 1'b0;
  logic [3:0]    sr_in = '0;

  logic [DW-1:0] pc_out, val_rn_out, val_rm_out;
  logic          imm_out;
  logic [11:0]   shift_operand_out;
  logic [23:0]   signed_imm24_out;
  logic [RW-1:0] dest_out;
  logic [3:0]    exe_cmd_out;
  logic          mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out;
  logic [3:0]    sr_out;
  logic          ld_or_str_out, valid_out;
  logic [15:0]   freeze_cnt_out, flush_cnt_out;

  id_exe_reg #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
    .dest_in(dest_in), .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in), .sr_in(sr_in),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
    .dest_out(dest_out), .exe_cmd_out(exe_cmd_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out), .b_out(b_out), .s_out(s_out),
    .sr_out(sr_out), .ld_or_str_out(ld_or_str_out), .valid_out(valid_out),
    .freeze_cnt_out(freeze_cnt_out), .flush_cnt_out(flush_cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] pc, rn, rm;
    logic          imm;
    logic [11:0]   sh;
    logic [23:0]   off;
    logic [RW-1:0] dest;
    logic [3:0]    cmd;
    logic          mr, mw, wb, b, s;
    logic [3:0]    sr;
    logic          ldst, valid;
  } bundle_t;

  bundle_t in_b, out_b, exp_b;
  int      exp_fcnt, exp_lcnt;
  int      vectors = 0, miscompares = 0;

  assign in_b  = {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm24_in, dest_in,
                  exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, sr_in,
                  mem_r_en_in | mem_w_en_in, 1'b1};
  assign out_b = {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm24_out, dest_out,
                  exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, sr_out,
                  ld_or_str_out, valid_out};

`ifdef ID_EXE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Model: a bubble is an all-zero bundle, a hold keeps the bundle, a load copies the decoded inputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_b = '0; exp_fcnt = 0; exp_lcnt = 0;
    end else begin
      if (PERF && flush) exp_lcnt = (exp_lcnt < 65535) ? exp_lcnt + 1 : 65535;
      else if (PERF && freeze) exp_fcnt = (exp_fcnt < 65535) ? exp_fcnt + 1 : 65535;
      if (flush) exp_b = '0;
      else if (!freeze) exp_b = in_b;
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("bundle", 256'(out_b), 256'(exp_b));
    check("freeze_cnt", 256'(freeze_cnt_out), 256'(exp_fcnt[15:0]));
    check("flush_cnt", 256'(flush_cnt_out), 256'(exp_lcnt[15:0]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("reset_valid", 256'(valid_out), 256'(0));

    pc_in = 32'h4; val_rm_in = 32'h8000_0001; imm_in = 1'b0; shift_operand_in = 12'h0E0;
    mem_r_en_in = 1'b1; wb_en_in = 1'b1; exe_cmd_in = 4'b0010; dest_in = 4'h3; sr_in = 4'hA;
    tick();
    check("load_pc", 256'(pc_out), 256'(32'h4));
    check("load_rm", 256'(val_rm_out), 256'(32'h8000_0001));
    check("load_ldst", 256'(ld_or_str_out), 256'(1));
    check("load_valid", 256'(valid_out), 256'(1));

    freeze = 1'b1; pc_in = 32'h8; mem_r_en_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_hold_pc", 256'(pc_out), 256'(32'h4));
    end
    freeze = 1'b0;
    tick();
    check("unfreeze_pc", 256'(pc_out), 256'(32'h8));

    flush = 1'b1; wb_en_in = 1'b1; b_in = 1'b1; exe_cmd_in = 4'b0010; pc_in = 32'hC;
    tick();
    check("flush_wb", 256'(wb_en_out), 256'(0));
    check("flush_b", 256'(b_out), 256'(0));
    check("flush_cmd", 256'(exe_cmd_out), 256'(0));
    check("flush_valid", 256'(valid_out), 256'(0));
    check("flush_pc", 256'(pc_out), 256'(0));
    flush = 1'b0;
    tick();
    check("post_flush_pc", 256'(pc_out), 256'(32'hC));
    check("post_flush_b", 256'(b_out), 256'(1));
    check("post_flush_valid", 256'(valid_out), 256'(1));

    flush = 1'b1; freeze = 1'b1;
    tick();
    check("ff_valid", 256'(valid_out), 256'(0));
    check("ff_freeze_cnt", 256'(freeze_cnt_out), 256'(PERF ? 3 : 0));
    check("ff_flush_cnt", 256'(flush_cnt_out), 256'(PERF ? 2 : 0));
    flush = 1'b0; freeze = 1'b0;

    for (int i = 0; i < 4; i++) begin
      pc_in = 32'h100 + 32'(i * 4); val_rn_in = 32'hA5A5_0000 ^ 32'(i); val_rm_in = ~val_rn_in;
      imm_in = i[0]; shift_operand_in = 12'hF00 | 12'(i); signed_imm24_in = 24'hFF_FFF0 + 24'(i);
      dest_in = 4'(i + 7); exe_cmd_in = 4'(i + 5); mem_r_en_in = (i == 1); mem_w_en_in = (i == 2);
      wb_en_in = i[1]; b_in = (i == 3); s_in = ~i[0]; sr_in = 4'(15 - i);
      tick();
    end
    check("store_ldst", 256'(ld_or_str_out), 256'(0));

    wb_en_in = 1'b1; pc_in = 32'h0000_0010;
    #2 rst = 1'b1;
    #1;
    check("rst_async_pc", 256'(pc_out), 256'(0));
    check("rst_async_wb", 256'(wb_en_out), 256'(0));
    check("rst_async_valid", 256'(valid_out), 256'(0));
    check("rst_async_cnt", 256'({freeze_cnt_out, flush_cnt_out}), 256'(0));
    tick();
    rst = 1'b0;
    tick();
    check("rst_release_pc", 256'(pc_out), 256'(32'h10));
    check("rst_release_valid", 256'(valid_out), 256'(1));

    freeze = 1'b1;
    repeat (70000) tick();
    check("freeze_sat", 256'(freeze_cnt_out), 256'(PERF ? 16'hFFFF : 16'h0000));
    freeze = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
